// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants, instruction classes and select encodings for the multi-cycle controller.
package mc_ctrl_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EXE  = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BR  = 3'd1;
  localparam logic [2:0] NPC_JT  = 3'd2;
  localparam logic [2:0] NPC_RS  = 3'd3;

  localparam logic [1:0] WA_RT = 2'd0;
  localparam logic [1:0] WA_RD = 2'd1;
  localparam logic [1:0] WA_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_ADDU, CL_SUBU, CL_ORI, CL_LUI, CL_LW,
    CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR, CL_JALR
  } instr_class_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alusrc;
    logic [1:0] ext_op;
    logic [1:0] wa_sel;
    logic [1:0] wd_sel;
  } dp_sel_t;

  function automatic dp_sel_t class_sel(input instr_class_e c);
    dp_sel_t s;
    s = '{alu_op: ALU_ADD, alusrc: 1'b0, ext_op: EXT_ZERO, wa_sel: WA_RT, wd_sel: WD_ALU};
    case (c)
      CL_ADDU: s.wa_sel = WA_RD;
      CL_SUBU: begin s.alu_op = ALU_SUB; s.wa_sel = WA_RD; end
      CL_ORI:  begin s.alu_op = ALU_OR;  s.alusrc = 1'b1; end
      CL_LUI:  begin s.alu_op = ALU_LUI; s.alusrc = 1'b1; s.ext_op = EXT_UPPER; end
      CL_LW:   begin s.alusrc = 1'b1; s.ext_op = EXT_SIGN; s.wd_sel = WD_DM; end
      CL_SW:   begin s.alusrc = 1'b1; s.ext_op = EXT_SIGN; end
      CL_BEQ:  s.alu_op = ALU_SUB;
      CL_JAL:  begin s.wa_sel = WA_RA; s.wd_sel = WD_PC4; end
      CL_JALR: begin s.wa_sel = WA_RD; s.wd_sel = WD_PC4; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface mc_ctrl_fsm_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic [31:0] pc_init;
  logic        pc_we;
  logic [2:0]  npc_sel;
  logic        ir_we;
  logic        reg_we;
  logic [1:0]  wa_sel;
  logic [1:0]  wd_sel;
  logic [2:0]  alu_op;
  logic        alusrc;
  logic [1:0]  ext_op;
  logic        mem_we;
  logic [2:0]  state;
  logic        halted;

  modport master (
    input  op, funct, zero,
    output pc_init, pc_we, npc_sel, ir_we, reg_we, wa_sel, wd_sel,
           alu_op, alusrc, ext_op, mem_we, state, halted
  );

  modport slave (
    output op, funct, zero,
    input  pc_init, pc_we, npc_sel, ir_we, reg_we, wa_sel, wd_sel,
           alu_op, alusrc, ext_op, mem_we, state, halted
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct to instruction-class decoder.
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_e cls
);

  always_comb begin
    cls = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CL_ADDU;
          FN_SUBU: cls = CL_SUBU;
          FN_JR:   cls = CL_JR;
          FN_JALR: cls = CL_JALR;
          default: cls = CL_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = CL_ORI;
      OP_LUI:  cls = CL_LUI;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset main controller (IF/ID/EXE/MEM/WB).
// Optional MC_CTRL_ILLEGAL_HALT_EN: unknown instructions enter a sticky HALT state.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  logic [2:0]   state_q, state_d;
  instr_class_e cls_q, cls_d, dec_cls;
  dp_sel_t      sel;

  mc_ctrl_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (dec_cls)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        cls_d = dec_cls;
        case (dec_cls)
          CL_J, CL_JR:     state_d = ST_IF;
          CL_JAL, CL_JALR: state_d = ST_WB;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
          CL_ILLEGAL:      state_d = ST_HALT;
`else
          CL_ILLEGAL:      state_d = ST_IF;
`endif
          default:         state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (cls_q)
          CL_BEQ:       state_d = ST_IF;
          CL_LW, CL_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM:  state_d = (cls_q == CL_LW) ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IF;
      cls_q   <= CL_ILLEGAL;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  assign sel         = class_sel(cls_q);
  assign bus.pc_init = PC_RESET;
  assign bus.state   = state_q;

  // ID acts on the live decode since the class is only being latched this cycle;
  // all outputs are held quiet while reset is asserted.
  always_comb begin
    bus.pc_we   = 1'b0;
    bus.npc_sel = NPC_PC4;
    bus.ir_we   = 1'b0;
    bus.reg_we  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.wa_sel  = WA_RT;
    bus.wd_sel  = WD_ALU;
    bus.alu_op  = ALU_ADD;
    bus.alusrc  = 1'b0;
    bus.ext_op  = EXT_ZERO;
    bus.halted  = 1'b0;
    if (!reset) begin
      if (state_q == ST_EXE || state_q == ST_MEM || state_q == ST_WB) begin
        bus.alu_op = sel.alu_op;
        bus.alusrc = sel.alusrc;
        bus.ext_op = sel.ext_op;
        bus.wa_sel = sel.wa_sel;
        bus.wd_sel = sel.wd_sel;
      end
      case (state_q)
        ST_IF: begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
        ST_ID: begin
          if (dec_cls == CL_J) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_JT;
          end else if (dec_cls == CL_JR) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_RS;
          end
        end
        ST_EXE: begin
          if (cls_q == CL_BEQ) begin
            bus.pc_we   = bus.zero;
            bus.npc_sel = NPC_BR;
          end
        end
        ST_MEM: bus.mem_we = (cls_q == CL_SW);
        ST_WB: begin
          bus.reg_we = 1'b1;
          if (cls_q == CL_JAL) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_JT;
          end else if (cls_q == CL_JALR) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_RS;
          end
        end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
        ST_HALT: bus.halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; expected control words are hand-written per state.
module tb_mc_ctrl_fsm;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.PC_RESET(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {state, pc_we, npc_sel, ir_we, reg_we, wa_sel, wd_sel, alu_op, alusrc, ext_op, mem_we, halted}
  function automatic logic [20:0] cw(input int st, input int pcwe, input int npc, input int irwe,
                                     input int regwe, input int wa, input int wd, input int alu,
                                     input int asrc, input int ext, input int mwe, input int h);
    logic [2:0] st3, npc3, alu3;
    logic [1:0] wa2, wd2, ext2;
    st3 = st[2:0]; npc3 = npc[2:0]; alu3 = alu[2:0];
    wa2 = wa[1:0]; wd2 = wd[1:0]; ext2 = ext[1:0];
    return {st3, pcwe[0], npc3, irwe[0], regwe[0], wa2, wd2, alu3, asrc[0], ext2, mwe[0], h[0]};
  endfunction

  function automatic logic [20:0] obs_cw();
    return {bus.state, bus.pc_we, bus.npc_sel, bus.ir_we, bus.reg_we, bus.wa_sel, bus.wd_sel,
            bus.alu_op, bus.alusrc, bus.ext_op, bus.mem_we, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nx(input string tag, input logic [20:0] exp);
    step();
    chk(tag, {11'd0, obs_cw()}, {11'd0, exp});
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    bus.op    = o;
    bus.funct = f;
    bus.zero  = z;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      total++;
      assert (!(bus.reg_we && bus.mem_we) && (!bus.ir_we || bus.state == 3'd0)) else begin
        bad++;
        $error("FAIL invariant reg_we=%0b mem_we=%0b ir_we=%0b state=%0d",
               bus.reg_we, bus.mem_we, bus.ir_we, bus.state);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [20:0] ifr, idr, zr;

  initial begin
    ifr = cw(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idr = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zr  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    issue(6'h00, 6'h00, 1'b0);
    step();
    nx("reset_hold", zr);
    chk("pc_init", bus.pc_init, 32'h0000_3000);
    reset = 1'b0;
    #1;
    chk("if_first", {11'd0, obs_cw()}, {11'd0, ifr});

    issue(6'h00, 6'h21, 1'b0);            // addu
    nx("addu_id", idr);
    nx("addu_exe", cw(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    nx("addu_wb", cw(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    nx("addu_if", ifr);

    issue(6'h23, 6'h00, 1'b0);            // lw
    nx("lw_id", idr);
    nx("lw_exe", cw(2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    nx("lw_mem", cw(3, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    nx("lw_wb", cw(4, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0));
    nx("lw_if", ifr);

    issue(6'h2B, 6'h00, 1'b0);            // sw
    nx("sw_id", idr);
    nx("sw_exe", cw(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    nx("sw_mem", cw(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    nx("sw_if", ifr);

    issue(6'h04, 6'h00, 1'b1);            // beq taken
    nx("beq1_id", idr);
    nx("beq1_exe", cw(2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    nx("beq1_if", ifr);

    issue(6'h04, 6'h00, 1'b0);            // beq not taken
    nx("beq0_id", idr);
    nx("beq0_exe", cw(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    nx("beq0_if", ifr);

    issue(6'h02, 6'h00, 1'b0);            // j
    nx("j_id", cw(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nx("j_if", ifr);

    issue(6'h00, 6'h08, 1'b0);            // jr
    nx("jr_id", cw(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nx("jr_if", ifr);

    issue(6'h03, 6'h00, 1'b0);            // jal
    nx("jal_id", idr);
    nx("jal_wb", cw(4, 1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 0));
    nx("jal_if", ifr);

    issue(6'h00, 6'h09, 1'b0);            // jalr
    nx("jalr_id", idr);
    nx("jalr_wb", cw(4, 1, 3, 0, 1, 1, 2, 0, 0, 0, 0, 0));
    nx("jalr_if", ifr);

    issue(6'h0D, 6'h00, 1'b0);            // ori
    nx("ori_id", idr);
    nx("ori_exe", cw(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    nx("ori_wb", cw(4, 0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0));
    nx("ori_if", ifr);

    issue(6'h0F, 6'h00, 1'b0);            // lui
    nx("lui_id", idr);
    nx("lui_exe", cw(2, 0, 0, 0, 0, 0, 0, 3, 1, 2, 0, 0));
    nx("lui_wb", cw(4, 0, 0, 0, 1, 0, 0, 3, 1, 2, 0, 0));
    nx("lui_if", ifr);

    issue(6'h00, 6'h23, 1'b0);            // subu
    nx("subu_id", idr);
    nx("subu_exe", cw(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    nx("subu_wb", cw(4, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    nx("subu_if", ifr);

    issue(6'h00, 6'h21, 1'b0);            // addu abandoned by reset in EXE
    nx("abort_id", idr);
    nx("abort_exe", cw(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    nx("abort_rst", zr);
    reset = 1'b0;
    #1;
    chk("abort_if", {11'd0, obs_cw()}, {11'd0, ifr});

`ifdef MC_CTRL_ILLEGAL_HALT_EN
    issue(6'h3F, 6'h00, 1'b0);
    nx("ill_id", idr);
    nx("ill_halt0", cw(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    nx("ill_halt1", cw(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    nx("ill_halt2", cw(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    reset = 1'b1;
    nx("ill_rst", zr);
    reset = 1'b0;
    #1;
    chk("ill_if", {11'd0, obs_cw()}, {11'd0, ifr});
    issue(6'h00, 6'h3F, 1'b0);
    nx("illfn_id", idr);
    nx("illfn_halt", cw(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    reset = 1'b1;
    nx("illfn_rst", zr);
    reset = 1'b0;
    #1;
    chk("illfn_if", {11'd0, obs_cw()}, {11'd0, ifr});
`else
    issue(6'h3F, 6'h00, 1'b0);
    nx("ill_id", idr);
    nx("ill_if", ifr);
    issue(6'h00, 6'h3F, 1'b0);
    nx("illfn_id", idr);
    nx("illfn_if", ifr);
`endif

    issue(6'h02, 6'h00, 1'b0);            // j after illegal: normal flow resumes
    nx("post_j_id", cw(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nx("post_j_if", ifr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
